// File: rtl/rvfi_ref_emitter_if.sv
// Instruction handshake plus RVFI retirement packet for rvfi_ref_emitter.
// master = instruction source / trace consumer, slave = the emitter.
interface rvfi_ref_emitter_if;
  logic        insn_valid;
  logic [31:0] insn_data;
  logic        insn_ready;
  logic        rvfi_valid;
  logic [31:0] rvfi_insn;
  logic [4:0]  rvfi_rs1;
  logic [4:0]  rvfi_rs2;
  logic [4:0]  rvfi_rd;
  logic [31:0] rvfi_pre_pc;
  logic [31:0] rvfi_post_pc;
  logic [31:0] rvfi_pre_rs1;
  logic [31:0] rvfi_pre_rs2;
  logic [31:0] rvfi_post_rd;
  logic        rvfi_post_trap;

  modport master (
    output insn_valid, insn_data,
    input  insn_ready, rvfi_valid, rvfi_insn, rvfi_rs1, rvfi_rs2, rvfi_rd,
           rvfi_pre_pc, rvfi_post_pc, rvfi_pre_rs1, rvfi_pre_rs2,
           rvfi_post_rd, rvfi_post_trap
  );

  modport slave (
    input  insn_valid, insn_data,
    output insn_ready, rvfi_valid, rvfi_insn, rvfi_rs1, rvfi_rs2, rvfi_rd,
           rvfi_pre_pc, rvfi_post_pc, rvfi_pre_rs1, rvfi_pre_rs2,
           rvfi_post_rd, rvfi_post_trap
  );
endinterface

// File: rtl/rvfi_ref_emitter.sv
// Multi-cycle RV32I reference core (no memory ops) that emits one RVFI packet
// per instruction; any unsupported or misaligned-target instruction traps and halts.
module rvfi_ref_emitter #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic              clk,
  input  logic              reset,
  rvfi_ref_emitter_if.slave bus
);

  typedef enum logic [1:0] {FETCH, EXEC, RETIRE, HALT} state_t;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pre_rs1;
    logic [XLEN-1:0] pre_rs2;
    logic [XLEN-1:0] post_rd;
    logic [XLEN-1:0] post_pc;
    logic            trap;
  } pkt_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     insn_q;
  logic [XLEN-1:0] rs1_val_q, rs2_val_q;
  pkt_t            pkt_q, pkt_d;
  logic [XLEN-1:0] rf [1:31];

  logic            accept;
  logic            retire;
  logic            ready;
  logic [XLEN-1:0] rs1_read, rs2_read;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default before the
  // case statement, so no path leaves a value held and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    retire  = 1'b0;
    accept  = 1'b0;
    case (state_q)
      FETCH: begin
        ready = 1'b1;
        if (bus.insn_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC:   state_d = RETIRE;
      RETIRE: begin
        retire  = 1'b1;
        state_d = pkt_q.trap ? HALT : FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // ---------------------------------------------------------------- register file
  assign rs1_read = (bus.insn_data[19:15] == 5'd0) ? '0 : rf[bus.insn_data[19:15]];
  assign rs2_read = (bus.insn_data[24:20] == 5'd0) ? '0 : rf[bus.insn_data[24:20]];

  // NOTE: the register file has no reset; software writes before it reads, and
  // leaving it out of the reset tree lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (retire && !pkt_q.trap && pkt_q.rd != 5'd0)
      rf[pkt_q.rd] <= pkt_q.post_rd;
  end

  // ---------------------------------------------------------------- datapath state
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      insn_q    <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      pkt_q     <= '0;
    end else begin
      if (accept) begin
        insn_q    <= bus.insn_data;
        rs1_val_q <= rs1_read;
        rs2_val_q <= rs2_read;
      end
      if (state_q == EXEC) pkt_q <= pkt_d;
      if (retire)          pc_q  <= pkt_q.post_pc;
    end
  end

  // ---------------------------------------------------------------- decode / execute
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd_f, rs1_f, rs2_f;
  logic [XLEN-1:0] imm_i, imm_b, imm_u, imm_j, op_b, alu_res, pc_plus4;
  logic [XLEN-1:0] result, target;
  logic            legal, uses_rs1, uses_rs2, writes_rd, redirect, taken, trap;

  assign opcode   = insn_q[6:0];
  assign rd_f     = insn_q[11:7];
  assign funct3   = insn_q[14:12];
  assign rs1_f    = insn_q[19:15];
  assign rs2_f    = insn_q[24:20];
  assign funct7   = insn_q[31:25];
  assign imm_i    = {{20{insn_q[31]}}, insn_q[31:20]};
  assign imm_b    = {{19{insn_q[31]}}, insn_q[31], insn_q[7], insn_q[30:25], insn_q[11:8], 1'b0};
  assign imm_u    = {insn_q[31:12], 12'b0};
  assign imm_j    = {{11{insn_q[31]}}, insn_q[31], insn_q[19:12], insn_q[20], insn_q[30:21], 1'b0};
  assign pc_plus4 = pc_q + XLEN'(4);
  assign op_b     = (opcode == OPC_OP) ? rs2_val_q : imm_i;

  // Shared ALU for OP and OP-IMM; bit 30 selects SUB (OP only) and SRA/SRAI.
  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000: alu_res = (opcode == OPC_OP && insn_q[30]) ? rs1_val_q - op_b : rs1_val_q + op_b;
      3'b001: alu_res = rs1_val_q << op_b[4:0];
      3'b010: alu_res = XLEN'($signed(rs1_val_q) < $signed(op_b));
      3'b011: alu_res = XLEN'(rs1_val_q < op_b);
      3'b100: alu_res = rs1_val_q ^ op_b;
      3'b101: alu_res = insn_q[30] ? XLEN'($signed(rs1_val_q) >>> op_b[4:0])
                                   : rs1_val_q >> op_b[4:0];
      3'b110: alu_res = rs1_val_q | op_b;
      default: alu_res = rs1_val_q & op_b;
    endcase
  end

  always_comb begin
    legal     = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    redirect  = 1'b0;
    taken     = 1'b0;
    result    = '0;
    target    = '0;
    case (opcode)
      OPC_LUI: begin
        legal = 1'b1; writes_rd = 1'b1; result = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1; writes_rd = 1'b1; result = pc_q + imm_u;
      end
      OPC_JAL: begin
        legal = 1'b1; writes_rd = 1'b1; result = pc_plus4;
        redirect = 1'b1; target = pc_q + imm_j;
      end
      OPC_JALR: begin
        legal = (funct3 == 3'b000); uses_rs1 = 1'b1; writes_rd = 1'b1;
        result = pc_plus4; redirect = 1'b1;
        target = (rs1_val_q + imm_i) & ~XLEN'(1);
      end
      OPC_BRANCH: begin
        legal    = (funct3 != 3'b010) && (funct3 != 3'b011);
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        case (funct3)
          3'b000:  taken = (rs1_val_q == rs2_val_q);
          3'b001:  taken = (rs1_val_q != rs2_val_q);
          3'b100:  taken = ($signed(rs1_val_q) <  $signed(rs2_val_q));
          3'b101:  taken = ($signed(rs1_val_q) >= $signed(rs2_val_q));
          3'b110:  taken = (rs1_val_q <  rs2_val_q);
          3'b111:  taken = (rs1_val_q >= rs2_val_q);
          default: taken = 1'b0;
        endcase
        redirect = taken; target = pc_q + imm_b;
      end
      OPC_OPIMM: begin
        uses_rs1 = 1'b1; writes_rd = 1'b1; result = alu_res;
        case (funct3)
          3'b001:  legal = (funct7 == 7'b0000000);
          3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
      end
      OPC_OP: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; result = alu_res;
        legal = (funct7 == 7'b0000000) ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      default: legal = 1'b0;
    endcase
  end

  assign trap = !legal || (redirect && target[1:0] != 2'b00);

  always_comb begin
    pkt_d         = '0;
    pkt_d.trap    = trap;
    pkt_d.rs1     = (legal && uses_rs1) ? rs1_f : 5'd0;
    pkt_d.rs2     = (legal && uses_rs2) ? rs2_f : 5'd0;
    pkt_d.pre_rs1 = (legal && uses_rs1) ? rs1_val_q : '0;
    pkt_d.pre_rs2 = (legal && uses_rs2) ? rs2_val_q : '0;
    if (!trap && writes_rd && rd_f != 5'd0) begin
      pkt_d.rd      = rd_f;
      pkt_d.post_rd = result;
    end
    pkt_d.post_pc = trap ? pc_q : (redirect ? target : pc_plus4);
  end

  // ---------------------------------------------------------------- RVFI outputs
  // Packet fields are forced to zero outside the retire cycle.
  assign bus.insn_ready     = ready;
  assign bus.rvfi_valid     = retire;
  assign bus.rvfi_insn      = retire ? insn_q        : '0;
  assign bus.rvfi_rs1       = retire ? pkt_q.rs1     : '0;
  assign bus.rvfi_rs2       = retire ? pkt_q.rs2     : '0;
  assign bus.rvfi_rd        = retire ? pkt_q.rd      : '0;
  assign bus.rvfi_pre_pc    = retire ? pc_q          : '0;
  assign bus.rvfi_post_pc   = retire ? pkt_q.post_pc : '0;
  assign bus.rvfi_pre_rs1   = retire ? pkt_q.pre_rs1 : '0;
  assign bus.rvfi_pre_rs2   = retire ? pkt_q.pre_rs2 : '0;
  assign bus.rvfi_post_rd   = retire ? pkt_q.post_rd : '0;
  assign bus.rvfi_post_trap = retire & pkt_q.trap;

endmodule
